// File: rtl/sfq_cell_pkg.sv
// Shared types and helpers for the tick-accurate RSFQ cell models.
package sfq_cell_pkg;

  typedef enum logic {EMPTY = 1'b0, LOADED = 1'b1} cell_state_e;

  localparam int POP_W = 64;

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max_v}) ? max_v : s[31:0];
  endfunction

  function automatic logic [31:0] popcount(input logic [POP_W-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < POP_W; i++) c = c + {31'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/sfq_or_n_tick_if.sv
// Pulse/status bundle of the N-input clocked-OR tick model.
interface sfq_or_n_tick_if #(
  parameter int N_IN  = 2,
  parameter int ERR_W = 8
);
  logic [N_IN-1:0]  in_tgl;
  logic             sfq_clk_tgl;
  logic             out_tgl;
  logic             err_pulse;
  logic             err_sticky;
  logic [ERR_W-1:0] err_count;
  logic             loaded;

  modport master (output in_tgl, sfq_clk_tgl,
                  input  out_tgl, err_pulse, err_sticky, err_count, loaded);
  modport slave  (input  in_tgl, sfq_clk_tgl,
                  output out_tgl, err_pulse, err_sticky, err_count, loaded);
endinterface

// File: rtl/sfq_toggle_delay.sv
// DELAY_TICKS-deep flip-request pipeline; o_flip strobes the tick before the
// output toggle is due, so a request at edge e flips its consumer at e+DELAY_TICKS.
module sfq_toggle_delay #(
  parameter int DELAY_TICKS = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  output logic o_flip
);
  logic [DELAY_TICKS-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (rst) r_sr <= '0;
    else     r_sr <= (r_sr << 1) | DELAY_TICKS'(i_req);
  end

  assign o_flip = r_sr[DELAY_TICKS-1];
endmodule

// File: rtl/sfq_or_n_tick.sv
// N-input clocked-OR RSFQ cell, tick-accurate: toggle-encoded pulses, setup/hold
// guards counted in clk ticks, violations counted instead of propagating X.
module sfq_or_n_tick
  import sfq_cell_pkg::*;
#(
  parameter int N_IN           = 2,
  parameter int DELAY_TICKS    = 7,
  parameter int CT0_TICKS      = 1,
  parameter int CT1_TICKS      = 4,
  parameter int IN_GUARD_TICKS = 2,
  parameter int ERR_W          = 8
) (
  input  logic          clk,
  input  logic          rst,
  sfq_or_n_tick_if.slave bus
);
  localparam int GW = $clog2(CT0_TICKS + CT1_TICKS + IN_GUARD_TICKS + 2);
  localparam int VW = $clog2(N_IN + 2);
  localparam logic [31:0] ERR_MAX = (ERR_W >= 32) ? 32'hFFFF_FFFF
                                                  : ((32'd1 << ERR_W) - 32'd1);

  cell_state_e      r_state, w_state_nxt;
  logic [N_IN-1:0]  r_prev_in, w_ev_in, w_acc, w_rej;
  logic             r_prev_clk, w_ev_clk;
  logic [GW-1:0]    r_cg, r_ig, w_cg_dec, w_ig_dec, w_cg_nxt, w_ig_nxt;
  logic [VW-1:0]    w_k, w_nviol;
  logic             w_flip_req, w_clk_viol, w_flip;
  logic             r_out, r_err_pulse, r_err_sticky;
  logic [ERR_W-1:0] r_err_cnt;

  always_comb begin
    w_ev_in     = bus.in_tgl ^ r_prev_in;
    w_ev_clk    = bus.sfq_clk_tgl ^ r_prev_clk;
    w_cg_dec    = (r_cg == '0) ? '0 : r_cg - GW'(1);
    w_ig_dec    = (r_ig == '0) ? '0 : r_ig - GW'(1);
    w_state_nxt = r_state;
    w_cg_nxt    = w_cg_dec;
    w_ig_nxt    = w_ig_dec;
    w_flip_req  = 1'b0;
    w_clk_viol  = 1'b0;

    // Data step first: events inside the hold window are dropped and counted.
    w_acc = (w_ig_dec != '0) ? '0 : w_ev_in;
    w_rej = (w_ig_dec != '0) ? w_ev_in : '0;
    w_k   = VW'(popcount(64'(w_acc)));
    if (w_k != '0) begin
      w_state_nxt = LOADED;
      w_cg_nxt    = (w_k == VW'(1) && r_state == EMPTY) ? GW'(CT0_TICKS)
                                                        : GW'(CT1_TICKS);
    end

    // Clock step sees the guard as just reloaded by this tick's inputs.
    if (w_ev_clk) begin
      if (w_cg_nxt != '0) begin
        w_clk_viol = 1'b1;
      end else if (w_state_nxt == LOADED) begin
        w_flip_req  = 1'b1;
        w_state_nxt = EMPTY;
        w_ig_nxt    = GW'(IN_GUARD_TICKS);
      end
    end

    w_nviol = VW'(popcount(64'(w_rej))) + VW'(w_clk_viol);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= EMPTY;
      r_cg         <= '0;
      r_ig         <= '0;
      r_prev_in    <= bus.in_tgl;
      r_prev_clk   <= bus.sfq_clk_tgl;
      r_out        <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cg         <= w_cg_nxt;
      r_ig         <= w_ig_nxt;
      r_prev_in    <= bus.in_tgl;
      r_prev_clk   <= bus.sfq_clk_tgl;
      r_out        <= r_out ^ w_flip;
      r_err_pulse  <= (w_nviol != '0);
      r_err_sticky <= r_err_sticky | (w_nviol != '0);
      r_err_cnt    <= ERR_W'(sat_add(32'(r_err_cnt), 32'(w_nviol), ERR_MAX));
    end
  end

  sfq_toggle_delay #(.DELAY_TICKS(DELAY_TICKS)) u_dly (
    .clk    (clk),
    .rst    (rst),
    .i_req  (w_flip_req),
    .o_flip (w_flip)
  );

  assign bus.out_tgl    = r_out;
  assign bus.err_pulse  = r_err_pulse;
  assign bus.err_sticky = r_err_sticky;
  assign bus.err_count  = r_err_cnt;
  assign bus.loaded     = (r_state == LOADED);
endmodule

// File: doc/sfq_or_n_tick.md
Name: sfq_or_n_tick

Overview:
- Tick-accurate, parametrised N-input clocked-OR model for RSFQ netlists.
- SFQ pulses are toggle-encoded: every level change on a line is one pulse.
- `clk` is the fine simulation time-base. Critical-timing windows and clock-to-output delay are counted in `clk` ticks.
- Sits in the cell library beside the per-gate timing models. Adds N inputs, an input hold guard, and counted, resettable error reporting instead of X-propagation.

Parameters:
- N_IN, 2, number of data inputs (>=1)
- DELAY_TICKS, 7, sfq-clock-event to out_tgl flip delay, in ticks (>=1)
- CT0_TICKS, 1, setup guard loaded by a first input pulse in EMPTY (>=1)
- CT1_TICKS, 4, setup guard loaded by an input pulse while already LOADED (>=1)
- IN_GUARD_TICKS, 2, hold guard on data inputs after an accepted sfq clock pulse; 0 disables
- ERR_W, 8, error counter width

Ports:
- clk, in, 1, simulation time-base clock
- rst, in, 1, synchronous active-high reset
- in_tgl, in, N_IN, toggle-encoded data pulses
- sfq_clk_tgl, in, 1, toggle-encoded SFQ clock
- out_tgl, out, 1, toggle-encoded output pulse
- err_pulse, out, 1, one-tick strobe per timing violation
- err_sticky, out, 1, set on first violation, cleared only by rst
- err_count, out, ERR_W, saturating violation count
- loaded, out, 1, cell state (1 = LOADED)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all of the following take effect at the same clk edge.
  - State goes to EMPTY.
  - Guard counters clear to 0.
  - Delay line clears, so pending output toggles are dropped.
  - Outputs go to 0.
  - Previous-value registers load the current in_tgl/sfq_clk_tgl, so no spurious event occurs after reset.
- Event detect: ev_i = in_tgl[i] ^ prev_i and ev_c = sfq_clk_tgl ^ prev_c, registered each tick.
- Two guard counters:
  - clk_guard (setup) and in_guard (hold); each is active when nonzero.
  - Each decrements by 1 per tick, saturating at 0.
  - A reload wins over the decrement in the same tick.
- Per-tick order: data inputs are evaluated first, then the sfq clock event, using guards updated by the input step.
- Data step:
  - An input event with in_guard active is a violation; that event is discarded.
  - Let k = number of accepted events this tick.
  - k=1 in EMPTY: state becomes LOADED, clk_guard loads CT0_TICKS.
  - k>=2 in EMPTY, or k>=1 in LOADED: state is LOADED, clk_guard loads CT1_TICKS.
- Clock step (on ev_c):
  - clk_guard active: violation. No output toggle, state unchanged.
  - LOADED and guard inactive:
    - A flip request enters the delay line.
    - State becomes EMPTY.
    - in_guard loads IN_GUARD_TICKS.
  - EMPTY and guard inactive: no action.
- Simultaneous input and clock event in one tick: the input loads clk_guard first, so the clock is a violation.
- Latency: a flip request accepted at edge e toggles out_tgl at edge e+DELAY_TICKS.
  - The delay line is a DELAY_TICKS-deep shift register, so back-to-back requests are all preserved.
- Violations: err_pulse is high for exactly one tick whenever >=1 violation occurs in that tick.
  - err_count adds the number of violations in the tick (max N_IN+1) and saturates at 2^ERR_W-1.
  - err_sticky is OR-accumulated.

Decomposition:
- Package sfq_cell_pkg holds:
  - the cell_state_e enum (EMPTY, LOADED)
  - a saturating-add function
  - a popcount function for event counting
- Natural sub-module: sfq_toggle_delay.
  - Parametrised DELAY_TICKS shift register with a sync-reset clear, producing a flip strobe.
  - Reused by future AND/XOR/DFF tick models.

Test Plan (defaults unless noted):
- Basic OR: rst, then in_tgl[0] flips at t=10 and sfq_clk flips at t=20 -> out_tgl rises at t=27; loaded is 1 from t=10 to t=20; err_count=0.
- Empty clock: sfq_clk flips at t=10 with no input -> out_tgl stays 0; no error.
- Setup window: in[0] at t=10 and in[1] at t=12 (clk_guard=4), then sfq_clk at t=14 -> err_pulse at t=14, no flip, loaded stays 1. A later sfq_clk at t=20 -> flip at t=27.
- Simultaneous inputs: in[0] and in[1] at t=10 -> clk_guard=4. sfq_clk at t=13 -> violation. sfq_clk at t=15 -> accepted.
- Hold guard: accepted sfq_clk at t=20, in[0] at t=21 -> violation and input discarded. in[0] at t=23 -> accepted, loaded=1.
- Reset mid-flight: accepted clock at t=20, rst at t=22 -> out_tgl stays 0 through t=30. Saturation with ERR_W=2 and 5 violations -> err_count=3, err_sticky=1 until rst.
